// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and line-level constants (TX and RX).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_tx_parity.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_parity
// Description : Combinational parity bit over the latched transmit byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_parity
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_par_typ,
    output logic                  o_parity
);

    logic w_xor;

    assign w_xor    = ^i_data;
    assign o_parity = (i_par_typ == PAR_ODD) ? ~w_xor : w_xor;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART serialiser: start, LSB-first data, optional parity, stop.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      DATA_VALID,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      Busy
);

    localparam int c_BIT_IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_BIT_IDX_W-1:0] c_LAST_BIT = c_BIT_IDX_W'(DATA_WIDTH - 1);

    tx_state_e                 r_state, w_state_next;
    logic [PRESCALE_WIDTH-1:0] r_cnt, w_cnt_next;
    logic [PRESCALE_WIDTH-1:0] r_prescale, w_prescale_next;
    logic [c_BIT_IDX_W-1:0]    r_bit_idx, w_bit_idx_next, w_bit_idx_inc;
    logic [DATA_WIDTH-1:0]     r_data, w_data_next;
    logic                      r_par_en, w_par_en_next;
    logic                      r_par_typ, w_par_typ_next;
    logic                      r_tx_out, w_tx_out_next;
    logic                      r_busy, w_busy_next;
    logic                      w_bit_done;
    logic                      w_parity;

    uart_tx_parity #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .i_data    (r_data),
        .i_par_typ (r_par_typ),
        .o_parity  (w_parity)
    );

    assign w_bit_done    = (r_cnt == (r_prescale - PRESCALE_WIDTH'(1)));
    assign w_bit_idx_inc = r_bit_idx + c_BIT_IDX_W'(1);

    // Outputs are registered, so each transition loads the level of the state being entered.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = w_bit_done ? '0 : r_cnt + PRESCALE_WIDTH'(1);
        w_prescale_next = r_prescale;
        w_bit_idx_next  = r_bit_idx;
        w_data_next     = r_data;
        w_par_en_next   = r_par_en;
        w_par_typ_next  = r_par_typ;
        w_tx_out_next   = r_tx_out;
        w_busy_next     = r_busy;

        case (r_state)
            IDLE: begin
                w_cnt_next    = '0;
                w_tx_out_next = STOP_BIT;
                w_busy_next   = 1'b0;
                if (DATA_VALID) begin
                    w_data_next     = P_DATA;
                    w_par_en_next   = PAR_EN;
                    w_par_typ_next  = PAR_TYP;
                    w_prescale_next = (Prescale == '0) ? PRESCALE_WIDTH'(1) : Prescale;
                    w_bit_idx_next  = '0;
                    w_state_next    = START;
                    w_tx_out_next   = START_BIT;
                    w_busy_next     = 1'b1;
                end
            end
            START: begin
                if (w_bit_done) begin
                    w_state_next  = DATA;
                    w_tx_out_next = r_data[0];
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    if (r_bit_idx == c_LAST_BIT) begin
                        w_state_next  = r_par_en ? PARITY : STOP;
                        w_tx_out_next = r_par_en ? w_parity : STOP_BIT;
                    end else begin
                        w_bit_idx_next = w_bit_idx_inc;
                        w_tx_out_next  = r_data[w_bit_idx_inc];
                    end
                end
            end
            PARITY: begin
                if (w_bit_done) begin
                    w_state_next  = STOP;
                    w_tx_out_next = STOP_BIT;
                end
            end
            STOP: begin
                if (w_bit_done) begin
                    w_state_next  = IDLE;
                    w_tx_out_next = STOP_BIT;
                    w_busy_next   = 1'b0;
                end
            end
            default: begin
                w_state_next  = IDLE;
                w_cnt_next    = '0;
                w_tx_out_next = STOP_BIT;
                w_busy_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_prescale <= PRESCALE_WIDTH'(1);
            r_bit_idx  <= '0;
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_tx_out   <= STOP_BIT;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_prescale <= w_prescale_next;
            r_bit_idx  <= w_bit_idx_next;
            r_data     <= w_data_next;
            r_par_en   <= w_par_en_next;
            r_par_typ  <= w_par_typ_next;
            r_tx_out   <= w_tx_out_next;
            r_busy     <= w_busy_next;
        end
    end

    assign TX_OUT = r_tx_out;
    assign Busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Directed, table-driven self-checking bench for uart_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic       TX_OUT;
    logic       Busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_typ;
        logic [5:0] prescale;
        int         eff_p;
        logic       exp_par;
    } vec_t;

    uart_tx #(
        .DATA_WIDTH     (8),
        .PRESCALE_WIDTH (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Caller is positioned at a negedge with the line idle; returns at the first idle negedge.
    task automatic send_frame(input vec_t v, input int pulse_at, input int abort_at, input string tag);
        int          nbits;
        int          len;
        logic [10:0] exp_bits;
        logic [10:0] rx;
        bit          aborted;
        nbits    = v.par_en ? 11 : 10;
        len      = nbits * v.eff_p;
        exp_bits = '1;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = v.data[i];
        if (v.par_en) exp_bits[9] = v.exp_par;
        rx      = '0;
        aborted = 1'b0;

        chk({tag, " pre-idle tx"}, TX_OUT, 1);
        chk({tag, " pre-idle busy"}, Busy, 0);
        P_DATA     = v.data;
        PAR_EN     = v.par_en;
        PAR_TYP    = v.par_typ;
        Prescale   = v.prescale;
        DATA_VALID = 1'b1;
        @(negedge clk);
        DATA_VALID = 1'b0;
        P_DATA     = ~v.data;
        PAR_EN     = ~v.par_en;
        PAR_TYP    = ~v.par_typ;
        Prescale   = v.prescale + 6'd5;

        for (int c = 0; c < len; c++) begin
            if (c > 0) @(negedge clk);
            if (c == abort_at) begin
                #2 rst = 1'b0;
                #1;
                chk({tag, " abort tx"}, TX_OUT, 1);
                chk({tag, " abort busy"}, Busy, 0);
                aborted = 1'b1;
                break;
            end
            if (c == pulse_at) begin
                DATA_VALID = 1'b1;
                P_DATA     = 8'h5A;
            end else if (c == pulse_at + 1) begin
                DATA_VALID = 1'b0;
            end
            chk($sformatf("%s tx c%0d", tag, c), TX_OUT, exp_bits[c / v.eff_p]);
            chk($sformatf("%s busy c%0d", tag, c), Busy, 1);
            if ((c % v.eff_p) == (v.eff_p / 2)) rx[c / v.eff_p] = TX_OUT;
        end

        if (!aborted) begin
            @(negedge clk);
            chk({tag, " end busy"}, Busy, 0);
            chk({tag, " end tx"}, TX_OUT, 1);
            chk({tag, " rx byte"}, rx[8:1], v.data);
            chk({tag, " rx stop"}, rx[nbits-1], 1);
            if (v.par_en) chk({tag, " rx parity"}, rx[9], v.exp_par);
        end
    endtask

    vec_t tbl[6];
    vec_t v45;
    vec_t b01;
    vec_t bff;

    initial begin
        rst        = 1'b0;
        DATA_VALID = 1'b1;
        P_DATA     = 8'h45;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Prescale   = 6'd8;

        //              data   pe    pt    pres   P   parity
        tbl[0] = '{8'h45, 1'b0, 1'b0, 6'd8,  8,  1'b0};
        tbl[1] = '{8'hAA, 1'b1, 1'b0, 6'd8,  8,  1'b0};
        tbl[2] = '{8'hA8, 1'b1, 1'b1, 6'd8,  8,  1'b0};
        tbl[3] = '{8'h45, 1'b1, 1'b0, 6'd3,  3,  1'b1};
        tbl[4] = '{8'h80, 1'b1, 1'b1, 6'd0,  1,  1'b0};
        tbl[5] = '{8'h3C, 1'b0, 1'b0, 6'd63, 63, 1'b0};
        v45    = '{8'h45, 1'b0, 1'b0, 6'd8,  8,  1'b0};
        b01    = '{8'h01, 1'b0, 1'b0, 6'd1,  1,  1'b0};
        bff    = '{8'hFF, 1'b0, 1'b0, 6'd1,  1,  1'b0};

        // Reset held with a pending request: nothing may start.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("reset tx %0d", i), TX_OUT, 1);
            chk($sformatf("reset busy %0d", i), Busy, 0);
        end
        DATA_VALID = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        chk("post-reset tx", TX_OUT, 1);
        chk("post-reset busy", Busy, 0);

        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i], -1, -1, $sformatf("vec%0d", i));
            @(negedge clk);
        end

        // Request during a frame is dropped.
        send_frame(v45, 20, -1, "midpulse");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("midpulse idle tx %0d", i), TX_OUT, 1);
            chk($sformatf("midpulse idle busy %0d", i), Busy, 0);
        end

        // Back-to-back at Prescale=1 with a single idle cycle between frames.
        send_frame(b01, -1, -1, "b2b0");
        send_frame(bff, -1, -1, "b2b1");
        @(negedge clk);

        // Reset in the middle of data bit 3, then a clean frame.
        send_frame(v45, -1, 36, "abort");
        @(negedge clk);
        chk("abort hold tx", TX_OUT, 1);
        chk("abort hold busy", Busy, 0);
        rst = 1'b1;
        @(negedge clk);
        send_frame(v45, -1, -1, "recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
